// File: rtl/edu_pkg.sv
// edu_pkg: shared constants and types for the PCI Edu register back-end.
// Register offsets, default ID, unmapped read value, decode and FSM enums.
package edu_pkg;

   localparam logic [31:0] EDU_ID_DEFAULT = 32'h010000ED;
   localparam logic [31:0] UNMAPPED_RD    = 32'hFFFFFFFF;

   localparam logic [7:0] OFF_ID         = 8'h00;
   localparam logic [7:0] OFF_LIVE       = 8'h04;
   localparam logic [7:0] OFF_FACT       = 8'h08;
   localparam logic [7:0] OFF_STATUS     = 8'h20;
   localparam logic [7:0] OFF_IRQ_STATUS = 8'h24;
   localparam logic [7:0] OFF_IRQ_RAISE  = 8'h60;
   localparam logic [7:0] OFF_IRQ_ACK    = 8'h64;

   localparam int STATUS_IRQ_EN_BIT = 7;

   typedef enum logic {
      FACT_IDLE,
      FACT_RUN
   } fact_state_e;

   typedef enum logic [2:0] {
      SEL_ID,
      SEL_LIVE,
      SEL_FACT,
      SEL_STATUS,
      SEL_IRQ_STATUS,
      SEL_IRQ_RAISE,
      SEL_IRQ_ACK,
      SEL_NONE
   } reg_sel_e;

endpackage

// File: rtl/edu_fact.sv
// edu_fact: iterative factorial engine, result = n! mod 2^32.
// Ports: clk, rst (sync, active-high), start/n in; busy, done (1-cycle), result out.
module edu_fact
   import edu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] n,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   fact_state_e state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] n_q, n_d;
   logic [31:0] fact_q, fact_d;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      fact_d  = fact_q;
      done    = 1'b0;
      unique case (state_q)
         FACT_IDLE: begin
            if (start) begin
               acc_d   = 32'd1;
               cnt_d   = n;
               n_d     = n;
               state_d = FACT_RUN;
            end
         end
         FACT_RUN: begin
            // cnt of 0 or 1 both end the run, so 0! and 1! take one cycle.
            if (cnt_q <= 32'd1) begin
               fact_d  = acc_q;
               done    = 1'b1;
               state_d = FACT_IDLE;
            end else begin
               acc_d = acc_q * cnt_q;
               cnt_d = cnt_q - 32'd1;
            end
         end
         default: state_d = FACT_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FACT_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         n_q     <= '0;
         fact_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         fact_q  <= fact_d;
      end
   end

   assign busy   = (state_q == FACT_RUN);
   // While running, the register reads back the operand being computed.
   assign result = busy ? n_q : fact_q;

endmodule

// File: rtl/edu_regs.sv
// edu_regs: BAR0 register file, factorial engine and level irq of PCI Edu.
// Ports: clk, rst (sync, active-high); acc_* access bus in, acc_ready out;
// rd_valid/rd_data read response (1 cycle after accept); irq level out.
// Macro EDU_FACTORIAL_EN enables the factorial engine (edu_fact).
module edu_regs
   import edu_pkg::*;
#(
   parameter logic [31:0] ID_VALUE = EDU_ID_DEFAULT,
   parameter int          ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              acc_valid,
   output logic              acc_ready,
   input  logic              acc_write,
   input  logic [ADDR_W-1:0] acc_addr,
   input  logic [3:0]        acc_be,
   input  logic [31:0]       acc_wdata,
   output logic              rd_valid,
   output logic [31:0]       rd_data,
   output logic              irq
);

   logic        init_q, init_d;
   logic        ready_q, ready_d;
   logic [31:0] live_q, live_d;
   logic        irq_en_q, irq_en_d;
   logic [31:0] irq_st_q, irq_st_d;
   logic        irq_q, irq_d;
   logic        rd_valid_q, rd_valid_d;
   logic [31:0] rd_data_q, rd_data_d;

   logic              xfer;
   logic              wr_ok;
   logic              rd_ok;
   logic [ADDR_W-1:0] waddr;
   reg_sel_e          sel;
   logic [31:0]       rd_word;

   logic        fact_busy;
   logic        fact_done;
   logic [31:0] fact_result;

   assign xfer  = acc_valid & ready_q;
   assign wr_ok = xfer & acc_write & (acc_be == 4'hF);
   assign rd_ok = xfer & ~acc_write;
   assign waddr = acc_addr & ~ADDR_W'(3);

`ifdef EDU_FACTORIAL_EN
   logic fact_start;

   // Writes landing while busy are dropped; the run in flight continues.
   assign fact_start = wr_ok & (sel == SEL_FACT) & ~fact_busy;

   edu_fact u_fact (
      .clk    (clk),
      .rst    (rst),
      .start  (fact_start),
      .n      (acc_wdata),
      .busy   (fact_busy),
      .done   (fact_done),
      .result (fact_result)
   );
`else
   assign fact_busy   = 1'b0;
   assign fact_done   = 1'b0;
   assign fact_result = 32'd0;
`endif

   always_comb begin
      sel = SEL_NONE;
      unique case (waddr)
         ADDR_W'(OFF_ID):         sel = SEL_ID;
         ADDR_W'(OFF_LIVE):       sel = SEL_LIVE;
         ADDR_W'(OFF_FACT):       sel = SEL_FACT;
         ADDR_W'(OFF_STATUS):     sel = SEL_STATUS;
         ADDR_W'(OFF_IRQ_STATUS): sel = SEL_IRQ_STATUS;
         ADDR_W'(OFF_IRQ_RAISE):  sel = SEL_IRQ_RAISE;
         ADDR_W'(OFF_IRQ_ACK):    sel = SEL_IRQ_ACK;
         default:                 sel = SEL_NONE;
      endcase
   end

   always_comb begin
      rd_word = UNMAPPED_RD;
      unique case (sel)
         SEL_ID:         rd_word = ID_VALUE;
         SEL_LIVE:       rd_word = ~live_q;
         SEL_FACT:       rd_word = fact_result;
         SEL_STATUS:     rd_word = {24'd0, irq_en_q, 6'd0, fact_busy};
         SEL_IRQ_STATUS: rd_word = irq_st_q;
         SEL_IRQ_RAISE:  rd_word = 32'd0;
         SEL_IRQ_ACK:    rd_word = 32'd0;
         default:        rd_word = UNMAPPED_RD;
      endcase
   end

   always_comb begin
      // ready holds off one extra cycle after reset via init_q.
      init_d     = 1'b1;
      ready_d    = init_q;
      live_d     = live_q;
      irq_en_d   = irq_en_q;
      irq_st_d   = irq_st_q;
      rd_valid_d = rd_ok;
      rd_data_d  = rd_ok ? rd_word : rd_data_q;
      irq_d      = |irq_st_q;
      if (wr_ok) begin
         unique case (sel)
            SEL_LIVE:      live_d   = acc_wdata;
            SEL_STATUS:    irq_en_d = acc_wdata[STATUS_IRQ_EN_BIT];
            SEL_IRQ_RAISE: irq_st_d = irq_st_q | acc_wdata;
            SEL_IRQ_ACK:   irq_st_d = irq_st_q & ~acc_wdata;
            default:       ;
         endcase
      end
      // Applied after the ack so a coincident completion keeps bit0 set.
      if (fact_done && irq_en_q) begin
         irq_st_d[0] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         init_q     <= 1'b0;
         ready_q    <= 1'b0;
         live_q     <= '0;
         irq_en_q   <= 1'b0;
         irq_st_q   <= '0;
         irq_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         init_q     <= init_d;
         ready_q    <= ready_d;
         live_q     <= live_d;
         irq_en_q   <= irq_en_d;
         irq_st_q   <= irq_st_d;
         irq_q      <= irq_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign acc_ready = ready_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_edu_regs.sv
// tb_edu_regs: randomized and directed bench for edu_regs against a
// transaction-level register model kept in the bench.
module tb_edu_regs;

`ifdef EDU_FACTORIAL_EN
   localparam bit FACT_EN = 1'b1;
`else
   localparam bit FACT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        acc_valid;
   logic        acc_ready;
   logic        acc_write;
   logic [7:0]  acc_addr;
   logic [3:0]  acc_be;
   logic [31:0] acc_wdata;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        irq;

   always #5 clk = ~clk;

   edu_regs #(.ID_VALUE(32'h010000ED), .ADDR_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .acc_valid (acc_valid),
      .acc_ready (acc_ready),
      .acc_write (acc_write),
      .acc_addr  (acc_addr),
      .acc_be    (acc_be),
      .acc_wdata (acc_wdata),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .irq       (irq)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Model state: what software would see, advanced once per clock edge.
   bit          m_ready, m_init, m_busy, m_irq_en, m_rdv, m_irq;
   logic [31:0] m_live, m_fact, m_n, m_irqst, m_rdd;
   int          edge_no, m_done_edge;

   function automatic logic [31:0] fact_of(input logic [31:0] n);
      logic [31:0] r = 32'd1;
      for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
      return r;
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] a);
      logic [7:0] wa = a & 8'hFC;
      case (wa)
         8'h00:   return 32'h010000ED;
         8'h04:   return ~m_live;
         8'h08:   return FACT_EN ? (m_busy ? m_n : m_fact) : 32'd0;
         8'h20:   return {24'd0, m_irq_en, 6'd0, m_busy};
         8'h24:   return m_irqst;
         8'h60:   return 32'd0;
         8'h64:   return 32'd0;
         default: return 32'hFFFFFFFF;
      endcase
   endfunction

   task automatic model_edge(input bit r, input bit v, input bit w,
                             input logic [7:0] a, input logic [3:0] be,
                             input logic [31:0] d);
      bit          xfer, comp, was_busy, en_pre;
      logic [31:0] rv, raise, ack;
      logic [7:0]  wa;
      edge_no++;
      if (r) begin
         m_ready = 0; m_init = 0; m_busy = 0; m_irq_en = 0;
         m_rdv = 0; m_irq = 0; m_live = 0; m_fact = 0; m_n = 0;
         m_irqst = 0; m_rdd = 0;
         return;
      end
      xfer     = v && m_ready;
      wa       = a & 8'hFC;
      rv       = model_read(a);
      was_busy = m_busy;
      en_pre   = m_irq_en;
      comp     = m_busy && (edge_no == m_done_edge);
      raise    = 0;
      ack      = 0;
      m_irq    = (m_irqst != 0);
      if (comp) begin
         m_fact = fact_of(m_n);
         m_busy = 0;
      end
      if (xfer && w && be == 4'hF) begin
         case (wa)
            8'h04: m_live = d;
            8'h08: if (FACT_EN && !was_busy) begin
               m_busy      = 1;
               m_n         = d;
               m_done_edge = edge_no + ((d == 0) ? 1 : int'(d));
            end
            8'h20: m_irq_en = d[7];
            8'h60: raise = d;
            8'h64: ack = d;
            default: ;
         endcase
      end
      m_irqst = (m_irqst & ~ack) | raise | {31'd0, comp && en_pre};
      m_rdv   = xfer && !w;
      if (m_rdv) m_rdd = rv;
      m_ready = m_init;
      m_init  = 1;
   endtask

   task automatic step(input bit r, input bit v, input bit w,
                       input logic [7:0] a, input logic [3:0] be,
                       input logic [31:0] d);
      @(negedge clk);
      rst = r; acc_valid = v; acc_write = w;
      acc_addr = a; acc_be = be; acc_wdata = d;
      @(posedge clk);
      model_edge(r, v, w, a, be, d);
      #1;
      check("acc_ready", {31'd0, acc_ready}, {31'd0, m_ready});
      check("rd_valid", {31'd0, rd_valid}, {31'd0, m_rdv});
      if (m_rdv) check($sformatf("rd_data@%02h", a), rd_data, m_rdd);
      if (r) check("rst_rd_data", rd_data, 32'd0);
      check("irq", {31'd0, irq}, {31'd0, m_irq});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 4'hF, 0);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      step(0, 1, 1, a, 4'hF, d);
   endtask

   task automatic rd(input logic [7:0] a);
      step(0, 1, 0, a, 4'hF, 0);
   endtask

   initial begin
      edge_no = 0; m_done_edge = 0;
      for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 4'hF, 0);
      idle(2);
      rd(8'h00);
      check("lit_id", rd_data, 32'h010000ED);
      rd(8'h04);
      check("lit_live_rst", rd_data, 32'hFFFFFFFF);
      wr(8'h04, 32'h12345678);
      rd(8'h04);
      check("lit_live", rd_data, 32'hEDCBA987);
      step(0, 1, 1, 8'h04, 4'h3, 32'h0);
      rd(8'h04);
      check("lit_live_be", rd_data, 32'hEDCBA987);
      wr(8'h20, 32'h80);
      wr(8'h08, 32'd5);
      rd(8'h20);
      idle(5);
      rd(8'h20);
      rd(8'h08);
      idle(2);
      rd(8'h24);
      wr(8'h08, 32'd13);
      idle(14);
      rd(8'h08);
      wr(8'h08, 32'd0);
      wr(8'h08, 32'd7);
      idle(2);
      rd(8'h08);
      wr(8'h64, 32'hFFFFFFFF);
      idle(2);
      wr(8'h60, 32'hA0);
      rd(8'h24);
      wr(8'h64, 32'h80);
      rd(8'h24);
      wr(8'h64, 32'h20);
      rd(8'h24);
      idle(2);
      wr(8'h08, 32'd12);
      idle(3);
      step(1, 0, 0, 8'h00, 4'hF, 0);
      step(1, 0, 0, 8'h00, 4'hF, 0);
      idle(15);
      rd(8'h20);
      rd(8'h08);
      rd(8'h24);
      rd(8'h40);
      check("lit_unmapped", rd_data, 32'hFFFFFFFF);

      for (int i = 0; i < 800; i++) begin
         logic [7:0]  offs [10];
         logic [7:0]  a;
         logic [3:0]  be;
         logic [31:0] d;
         bit          r, v, w;
         offs = '{8'h00, 8'h04, 8'h08, 8'h20, 8'h24,
                  8'h60, 8'h64, 8'h40, 8'h0C, 8'hFC};
         a  = offs[$urandom_range(0, 9)] | 8'($urandom_range(0, 3));
         r  = ($urandom_range(0, 199) == 0);
         v  = ($urandom_range(0, 3) != 0);
         w  = $urandom_range(0, 1) != 0;
         be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         d  = $urandom;
         if ((a & 8'hFC) == 8'h08) d = 32'($urandom_range(0, 13));
         step(r, v, w, a, be, d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
